// File: rtl/alu_seq_exec_g7_pkg.sv
// Shared ALU definitions (the riscv_defines_g7 set): operation codes produced
// by the ALU control decoder, the result record and a single-cycle evaluator.
// FSM state encodings stay local to alu_seq_exec_g7.
// Optional feature macro: G7_ALU_SLT_EN (enables code 4'b0111 = SLT).
package alu_seq_exec_g7_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic        ill;
    logic [31:0] res;
  } alu_res_t;

  // Single-cycle operations. SRL is only routed here with shamt 0, so its
  // result is simply a; non-zero shifts go through alu_shift_g7.
  function automatic alu_res_t alu_eval(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    alu_res_t r;
    r.ill = 1'b0;
    r.res = 32'd0;
    case (op)
      ALU_AND: r.res = a & b;
      ALU_OR:  r.res = a | b;
      ALU_ADD: r.res = a + b;
      ALU_SUB: r.res = a - b;
      ALU_SRL: r.res = a;
`ifdef G7_ALU_SLT_EN
      ALU_SLT: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
      // Unknown/undriven decoder codes fall here too and read as illegal.
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_exec_g7_shift.sv
// Iterative logical right shifter: 1 bit per cycle, zero fill.
// Ports: clk, rst_n (async low); i_load starts a shift of i_a by i_shamt
// (i_shamt must be non-zero); o_done pulses the cycle o_q holds the final
// value.
// The first shift is applied while loading, so the counter starts at
// shamt-1 and o_done appears shamt-1 cycles after load.
module alu_shift_g7 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_a,
  input  logic [4:0]  i_shamt,
  output logic        o_done,
  output logic [31:0] o_q
);
  logic [31:0] r_sr;
  logic [4:0]  r_cnt;
  logic        r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= 32'd0;
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_sr   <= i_a >> 1;
      r_cnt  <= i_shamt - 5'd1;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != 5'd0) begin
        r_sr  <= r_sr >> 1;
        r_cnt <= r_cnt - 5'd1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == 5'd0);
  assign o_q    = r_sr;
endmodule

// File: rtl/alu_seq_exec_g7.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Ports: clk, rst_n (async low); in_valid/in_ready + ALUControl, a, b accept
// an operation in IDLE; out_valid/out_ready + result, zero, illegal present
// it in DONE. AND/OR/ADD/SUB/SRL(shamt 0)/illegal complete in 1 cycle;
// SRL by N>0 completes N+1 cycles after acceptance via alu_shift_g7.
// Optional feature macro: G7_ALU_SLT_EN (adds SLT, code 4'b0111).
module alu_seq_exec_g7
  import alu_seq_exec_g7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e      r_state;
  logic        r_in_ready, r_out_valid, r_zero, r_illegal;
  logic [31:0] r_result;

  logic        w_accept, w_iter, w_sh_done;
  logic [31:0] w_sh_q;
  alu_res_t    w_eval;

  // r_in_ready mirrors S_IDLE, so it doubles as the acceptance qualifier.
  assign w_accept = in_valid && r_in_ready;
  assign w_iter   = (ALUControl == ALU_SRL) && (b[4:0] != 5'd0);
  assign w_eval   = alu_eval(ALUControl, a, b);

  alu_shift_g7 u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept && w_iter),
    .i_a     (a),
    .i_shamt (b[4:0]),
    .o_done  (w_sh_done),
    .o_q     (w_sh_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_in_ready <= 1'b0;
          if (w_iter) begin
            r_state <= S_SHIFT;
          end else begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_eval.res;
            r_zero      <= (w_eval.res == 32'd0);
            r_illegal   <= w_eval.ill;
          end
        end
        S_SHIFT: if (w_sh_done) begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_sh_q;
          r_zero      <= (w_sh_q == 32'd0);
          r_illegal   <= 1'b0;
        end
        // Result fields are left untouched here, so they hold under backpressure.
        S_DONE: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_seq_exec_g7.sv
module tb_alu_seq_exec_g7;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;

  alu_seq_exec_g7 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: result from plain arithmetic; timing as "done N edges after
  // acceptance" where N = shamt for a real SRL, else 0.
  function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'b0000: return {1'b0, x & y};
      4'b0001: return {1'b0, x | y};
      4'b0010: return {1'b0, x + y};
      4'b0110: return {1'b0, x - y};
      4'b0101: return {1'b0, x >> y[4:0]};
`ifdef G7_ALU_SLT_EN
      4'b0111: return {1'b0, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0};
`endif
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  logic        m_valid = 1'b0, m_ill = 1'b0;
  logic [31:0] m_res = 32'd0;
  int          m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (in_valid) begin
      {m_ill, m_res} <= ref_op(ALUControl, a, b);
      if (ALUControl == 4'b0101 && b[4:0] != 5'd0) m_wait <= int'(b[4:0]);
      else m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_illegal", illegal, 0);
    end else begin
      chk("m_in_ready", in_ready, (!m_valid && m_wait == 0));
      chk("m_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("m_result", result, m_res);
        chk("m_zero", zero, (m_res == 32'd0));
        chk("m_illegal", illegal, m_ill);
      end
    end
  end

  // Called at a negedge; returns at a negedge after the output handshake.
  task automatic do_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input int hold, output logic [31:0] r, output int lat,
                       output logic z, output logic il, output logic rdy_low);
    in_valid = 1'b1; ALUControl = op; a = ia; b = ib; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1; rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    r = result; z = zero; il = illegal;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      chk("hold_result", result, r);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          lat;
    logic        z, il, rl, seen;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Accepted on the first rising edge after release.
    do_op(4'b0010, 32'h7FFFFFFF, 32'd1, 0, r, lat, z, il, rl);
    chk("add_result", r, 32'h80000000); chk("add_zero", z, 0); chk("add_lat", lat, 1);

    do_op(4'b0110, 32'd5, 32'd5, 0, r, lat, z, il, rl);
    chk("sub_eq_result", r, 32'd0); chk("sub_eq_zero", z, 1);
    do_op(4'b0110, 32'd0, 32'd1, 0, r, lat, z, il, rl);
    chk("sub_wrap_result", r, 32'hFFFFFFFF); chk("sub_wrap_zero", z, 0);

    do_op(4'b0101, 32'h80000000, 32'd31, 0, r, lat, z, il, rl);
    chk("srl31_result", r, 32'd1); chk("srl31_lat", lat, 32); chk("srl31_in_ready_low", rl, 1);
    do_op(4'b0101, 32'hDEADBEEF, 32'd0, 0, r, lat, z, il, rl);
    chk("srl0_result", r, 32'hDEADBEEF); chk("srl0_lat", lat, 1);
    do_op(4'b0101, 32'hF0000000, 32'h00000024, 0, r, lat, z, il, rl);
    chk("srl4_result", r, 32'h0F000000); chk("srl4_lat", lat, 5);

    do_op(4'b0001, 32'h000000F0, 32'h0000000F, 5, r, lat, z, il, rl);
    chk("or_bp_result", r, 32'hFF); chk("or_bp_lat", lat, 1);
    do_op(4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 0, r, lat, z, il, rl);
    chk("and_result", r, 32'h0F000F00);

    do_op(4'b1111, 32'h123, 32'd4, 0, r, lat, z, il, rl);
    chk("ill_flag", il, 1); chk("ill_result", r, 0); chk("ill_zero", z, 1); chk("ill_lat", lat, 1);
    do_op(4'b0111, 32'hFFFFFFFF, 32'd0, 0, r, lat, z, il, rl);
`ifdef G7_ALU_SLT_EN
    chk("slt_result", r, 32'd1); chk("slt_illegal", il, 0);
`else
    chk("slt_off_illegal", il, 1); chk("slt_off_result", r, 0); chk("slt_off_zero", z, 1);
`endif

    // Reset mid-shift aborts the operation.
    in_valid = 1'b1; ALUControl = 4'b0101; a = 32'hFFFFFFFF; b = 32'd20;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1 chk("abort_out_valid", out_valid, 0); chk("abort_result", result, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("abort_no_result", seen, 0);
    do_op(4'b0010, 32'd2, 32'd3, 0, r, lat, z, il, rl);
    chk("post_rst_add_result", r, 32'd5); chk("post_rst_add_lat", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
